// File: rtl/saber_core_host_sequencer.sv
// saber_core_host_sequencer: turns a valid/ready request stream into ComputeCoreWrapper control words.
// Defining SEQ_TIMEOUT_EN bounds the instruction completion wait to TIMEOUT_CYCLES.
module saber_core_host_sequencer #(
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [9:0]  req_addr,
    input  logic [63:0] req_data,
    input  logic [4:0]  req_ins,
    input  logic [9:0]  req_op1,
    input  logic [9:0]  req_op2,
    input  logic [9:0]  req_op3,
    input  logic [34:0] req_cfg,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] control_low_word,
    output logic [31:0] control_high_word,
    output logic [31:0] dina_ext_low_word,
    output logic [31:0] dina_ext_high_word,
    input  logic [31:0] dout_ext_low_word,
    input  logic [31:0] dout_ext_high_word,
    input  logic [31:0] status,
    output logic        busy
);
    typedef enum logic [3:0] {
        IDLE, WRITE, RD_WAIT, RD_RSP, I_CLR, I_ISSUE, I_WAIT, I_ACK, I_RSP, CFG
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'd0, OP_READ = 2'd1, OP_INSTR = 2'd2;

    state_t      state, state_d;
    logic [63:0] ctrl, ctrl_d, dina;
    logic [34:0] instr;
    logic [2:0]  cnt;
    logic        accept, done, timed_out;

    function automatic logic [63:0] word(input logic [9:0] addr, input logic wea,
                                         input logic [34:0] cmd, input logic we0, input logic we1);
        return {16'b0, we1, we0, cmd, wea, addr};
    endfunction

    assign req_ready = state == IDLE || state == WRITE;
    assign accept    = req_valid && req_ready;
    assign busy      = state != IDLE;
    assign rsp_valid = state == RD_RSP || state == I_RSP;
    assign {control_high_word, control_low_word}   = ctrl;
    assign {dina_ext_high_word, dina_ext_low_word} = dina;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          expired;
    assign expired = status == '0 && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign done    = status != '0 || expired;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt      <= '0;
            timed_out <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            tcnt <= state == I_WAIT ? tcnt + 1'b1 : '0;
            if (state == I_WAIT) timed_out <= expired;
            if (state == I_ACK) rsp_err <= timed_out;
        end
    end
`else
    assign done      = status != '0;
    assign timed_out = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, WRITE: state_d = !accept ? IDLE :
                                   req_op == OP_WRITE ? WRITE :
                                   req_op == OP_READ  ? RD_WAIT :
                                   req_op == OP_INSTR ? I_CLR : CFG;
            RD_WAIT:     state_d = cnt == 3'(READ_LATENCY) ? RD_RSP : RD_WAIT;
            RD_RSP:      state_d = rsp_ready ? IDLE : RD_RSP;
            I_CLR:       state_d = I_ISSUE;
            I_ISSUE:     state_d = I_WAIT;
            I_WAIT:      state_d = done ? I_ACK : I_WAIT;
            I_ACK:       state_d = I_RSP;
            I_RSP:       state_d = rsp_ready ? IDLE : I_RSP;
            default:     state_d = IDLE;
        endcase
    end

    // Control word for the cycle after the next clock edge; the read address is held through RD_WAIT.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            WRITE:        ctrl_d = word(req_addr, 1'b1, '0, 1'b0, 1'b0);
            RD_WAIT:      ctrl_d = state == RD_WAIT ? ctrl : word(req_addr, 1'b0, '0, 1'b0, 1'b0);
            I_CLR, I_ACK: ctrl_d = word('0, 1'b0, '0, 1'b1, 1'b0);
            I_ISSUE:      ctrl_d = word('0, 1'b0, instr, 1'b1, 1'b0);
            I_WAIT:       ctrl_d = word('0, 1'b0, instr, 1'b0, 1'b0);
            CFG:          ctrl_d = word('0, 1'b0, req_cfg, 1'b0, 1'b1);
            default:      ctrl_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            dina     <= '0;
            instr    <= '0;
            cnt      <= '0;
            rsp_data <= '0;
        end else begin
            ctrl <= ctrl_d;
            cnt  <= state == RD_WAIT ? cnt + 1'b1 : '0;
            if (accept && req_op == OP_WRITE) dina <= req_data;
            if (accept && req_op == OP_INSTR) instr <= {req_op3, req_op2, req_op1, req_ins};
            if (state == RD_WAIT && cnt == 3'(READ_LATENCY))
                rsp_data <= {dout_ext_high_word, dout_ext_low_word};
            if (state == I_ACK) rsp_data <= {32'b0, timed_out ? 32'b0 : status};
        end
    end
endmodule

// File: tb/tb_saber_core_host_sequencer.sv
// tb_saber_core_host_sequencer: scoreboard bench with a behavioural core model and reference memory.
module tb_saber_core_host_sequencer;
    localparam int L  = 2;
    localparam int TO = 16;

    logic        clk = 0, rst_n = 0;
    logic        req_valid = 0, req_ready, rsp_valid, rsp_ready = 0, rsp_err, busy;
    logic [1:0]  req_op = 0;
    logic [9:0]  req_addr = 0, req_op1 = 0, req_op2 = 0, req_op3 = 0;
    logic [4:0]  req_ins = 0;
    logic [63:0] req_data = 0, rsp_data;
    logic [34:0] req_cfg = 0;
    logic [31:0] control_low_word, control_high_word, dina_ext_low_word, dina_ext_high_word;
    logic [31:0] dout_ext_low_word, dout_ext_high_word;
    logic [31:0] status = 0;

    saber_core_host_sequencer #(.READ_LATENCY(L), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_data(req_data), .req_ins(req_ins), .req_op1(req_op1),
        .req_op2(req_op2), .req_op3(req_op3), .req_cfg(req_cfg), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .control_low_word(control_low_word), .control_high_word(control_high_word),
        .dina_ext_low_word(dina_ext_low_word), .dina_ext_high_word(dina_ext_high_word),
        .dout_ext_low_word(dout_ext_low_word), .dout_ext_high_word(dout_ext_high_word),
        .status(status), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] data; logic err; int due; } rsp_t;
    typedef struct { int kind; logic [9:0] addr; logic [63:0] data; logic [34:0] cmd; int delay; logic [31:0] stat; } ev_t;

    rsp_t        rq[$];
    ev_t         eq[$];
    logic [63:0] ref_mem[1024];
    logic [63:0] core_mem[1024];
    logic [9:0]  pipe[L];
    int          checks = 0, errors = 0, cyc = 0, stall = 0;
    int          wr_n = 0, wr_first = 0, wr_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    // Core memory: writes land on the edge after the write word; reads return after L cycles.
    always @(posedge clk) begin
        if (control_low_word[10]) core_mem[control_low_word[9:0]] <= {dina_ext_high_word, dina_ext_low_word};
        pipe[0] <= control_low_word[9:0];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign {dout_ext_high_word, dout_ext_low_word} = core_mem[pipe[L-1]];

    // Core-side monitor: checks each control word against the expected event stream and drives status.
    logic [63:0] cw, pw = 0;
    logic        issued = 0, clr_pending = 0, cfg_next = 0;
    int          dn = -1, issue_cyc = 0, exp_ack;
    ev_t         cur, ce;
    always @(negedge clk) begin
        if (!rst_n) begin
            issued = 0; clr_pending = 0; cfg_next = 0; status = '0; dn = -1; pw = '0;
        end else begin
            cw = {control_high_word, control_low_word};
            if (clr_pending) begin status = '0; clr_pending = 0; end
            if (cfg_next) check("idle_after_cfg", cw, 64'd0);
            cfg_next = 0;
            if (cw[10] || cw[47] || (cw[46] && cw[45:11] != '0)) begin
                if (eq.size() == 0) fail_now("unexpected core write/config/issue word");
                else begin
                    ce = eq.pop_front();
                    if (cw[10]) begin
                        check("wr_kind", 64'(ce.kind), 64'd0);
                        check("wr_word", cw, {16'b0, 2'b0, 35'b0, 1'b1, ce.addr});
                        check("wr_data", {dina_ext_high_word, dina_ext_low_word}, ce.data);
                        if (wr_n == 0) wr_first = cyc;
                        wr_last = cyc;
                        wr_n++;
                    end else if (cw[47]) begin
                        check("cfg_kind", 64'(ce.kind), 64'd3);
                        check("cfg_word", cw, {16'b0, 1'b1, 1'b0, ce.cmd, 11'b0});
                        cfg_next = 1;
                    end else begin
                        check("ins_kind", 64'(ce.kind), 64'd2);
                        check("issue_word", cw, {16'b0, 1'b0, 1'b1, ce.cmd, 11'b0});
                        check("clear_before_issue", pw, 64'h0000_4000_0000_0000);
                        issued = 1; cur = ce; issue_cyc = cyc; dn = ce.delay;
                    end
                end
            end else if (issued && cw[46]) begin
                exp_ack = cur.delay < 0 ? issue_cyc + 1 + TO : issue_cyc + (cur.delay == 0 ? 2 : cur.delay + 1);
                check("ack_word", cw, 64'h0000_4000_0000_0000);
                check("ack_when_done", status != 0, cur.delay >= 0);
                check("ack_cycle", 64'(cyc), 64'(exp_ack));
                issued = 0; clr_pending = 1;
            end else if (issued) check("wait_word", cw, {16'b0, 2'b0, cur.cmd, 11'b0});
            if (issued && dn >= 0) begin
                if (dn == 0) status = cur.stat;
                dn--;
            end
            pw = cw;
        end
    end

    // Response monitor: pops the scoreboard on each new response and checks stall behaviour.
    logic        in_rsp = 0, hs_prev = 0;
    logic [63:0] held;
    rsp_t        r;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp = 0; hs_prev = 0; rsp_ready = 0;
        end else begin
            if (hs_prev) check("rsp_valid_drop", rsp_valid, 0);
            hs_prev = 0;
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (rq.size() == 0) fail_now("unexpected response");
                    else begin
                        r = rq.pop_front();
                        check("rsp_data", rsp_data, r.data);
                        check("rsp_err", rsp_err, r.err);
                        if (r.due >= 0) check("rsp_cycle", 64'(cyc), 64'(r.due));
                    end
                    held = rsp_data; in_rsp = 1;
                end else begin
                    check("rsp_stable", rsp_data, held);
                    check("req_ready_stalled", req_ready, 0);
                end
                rsp_ready = stall > 0 ? 1'b0 : ($urandom_range(0, 2) != 0);
                if (stall > 0) stall--;
                hs_prev = rsp_ready;
                if (rsp_ready) in_rsp = 0;
            end else begin
                if (in_rsp) fail_now("rsp_valid dropped while stalled");
                in_rsp = 0; rsp_ready = 0;
            end
        end
    end

    task automatic send(input int op, input logic [9:0] addr, input logic [63:0] data, input logic [34:0] pl,
                        input int delay, input logic [31:0] stat, input bit no_rsp);
        int w = 0;
        req_op = 2'(op); req_addr = addr; req_data = data; req_cfg = pl;
        {req_op3, req_op2, req_op1, req_ins} = pl;
        req_valid = 1;
        while (!req_ready && w < 500) begin @(negedge clk); w++; end
        if (!req_ready) begin
            fail_now("req_ready never asserted");
            req_valid = 0;
            return;
        end
        case (op)
            0: begin ref_mem[addr] = data; eq.push_back('{0, addr, data, '0, 0, '0}); end
            1: rq.push_back('{ref_mem[addr], 1'b0, cyc + L + 2});
            2: begin
                eq.push_back('{2, '0, '0, pl, delay, stat});
                if (delay >= 0) rq.push_back('{{32'b0, stat}, 1'b0, -1});
`ifdef SEQ_TIMEOUT_EN
                else if (!no_rsp) rq.push_back('{64'd0, 1'b1, -1});
`endif
            end
            default: eq.push_back('{3, '0, '0, pl, 0, '0});
        endcase
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic drain();
        int w = 0;
        while ((rq.size() != 0 || busy) && w < 5000) begin @(negedge clk); w++; end
        if (w >= 5000) fail_now("drain timed out");
        check("events_consumed", 64'(eq.size()), 64'd0);
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_ctrl"}, {control_high_word, control_low_word}, 64'd0);
        check({tag, "_dina"}, {dina_ext_high_word, dina_ext_low_word}, 64'd0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 64'd0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    logic [34:0] ins_pl;
    logic [63:0] rnd;
    int          op;
    initial begin
        repeat (3) @(negedge clk);
        reset_check("reset");
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 128; i++) begin
            send(0, 10'(i), i == 0 ? 64'hdb0cb67a17a9aeeb : {$urandom, $urandom}, '0, 0, '0, 0);
            if (i == 0) begin
                check("w0_ctrl_low", control_low_word, 32'h00000400);
                check("w0_ctrl_high", control_high_word, 32'h0);
                check("w0_dina_high", dina_ext_high_word, 32'hdb0cb67a);
                check("w0_dina_low", dina_ext_low_word, 32'h17a9aeeb);
            end
        end
        @(negedge clk);
        check("idle_after_write", {control_high_word, control_low_word}, 64'd0);
        drain();
        check("stream_words", 64'(wr_n), 64'd128);
        check("stream_span", 64'(wr_last - wr_first), 64'd127);

        send(3, '0, '0, 35'((32 << 16) | 32), 0, '0, 0);
        check("cfg_high", control_high_word, 32'h00008001);
        check("cfg_low", control_low_word, 32'h00010000);
        drain();

        send(2, '0, '0, {10'd124, 10'd0, 10'd124, 5'd1}, 50, 32'd1, 0);
        check("clr_high", control_high_word, 32'h4000);
        check("clr_low", control_low_word, 32'h0);
        @(negedge clk);
        check("issue_high", control_high_word, 32'h47C0);
        check("issue_low", control_low_word, 32'h007C0800);
        @(negedge clk);
        check("wait_high", control_high_word, 32'h07C0);
        check("wait_low", control_low_word, 32'h007C0800);
        drain();

        send(0, 10'd5, 64'h1122334455667788, '0, 0, '0, 0);
        stall = 3;
        send(1, 10'd5, '0, '0, 0, '0, 0);
        drain();

        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            op = op < 4 ? 0 : op < 7 ? 1 : op < 8 ? 2 : 3;
            rnd = {$urandom, $urandom};
            ins_pl = {10'($urandom), 10'($urandom), 10'($urandom), 5'($urandom_range(1, 31))};
            send(op, 10'($urandom_range(0, 31)), rnd, op == 2 ? ins_pl : rnd[34:0],
                 $urandom_range(0, 12), $urandom_range(1, 32'hffff_ffff), 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();

`ifdef SEQ_TIMEOUT_EN
        send(2, '0, '0, {10'd3, 10'd2, 10'd1, 5'd7}, -1, '0, 0);
        drain();
        send(2, '0, '0, {10'd3, 10'd2, 10'd1, 5'd7}, -1, '0, 1);
        repeat (6) @(negedge clk);
`else
        send(2, '0, '0, {10'd3, 10'd2, 10'd1, 5'd7}, -1, '0, 1);
        repeat (1000) @(negedge clk);
        check("still_waiting_busy", busy, 1);
        check("still_waiting_no_rsp", rsp_valid, 0);
`endif
        check("mid_instr_busy", busy, 1);
        rst_n = 0;
        #1;
        reset_check("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        reset_check("after_reset");

        send(1, 10'd5, '0, '0, 0, '0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end
endmodule
